// File: rtl/chaos_pkg.sv
// Shared constants and key-triple type for the chaotic key pipeline
// (extractor, key FIFO and XOR diffuser).
package chaos_pkg;
  localparam int KEY_W = 23;
  localparam int PIX_W = 8;
  localparam logic [1:0] SEL_LAST = 2'd2;

  typedef logic [0:2][KEY_W-1:0] key_triple_t;
endpackage

// File: rtl/key_fifo.sv
// Power-of-two deep FIFO of key triples. Holds occupancy count and full/empty flags.
module key_fifo
  import chaos_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = key_triple_t,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  T              din,
  output T              head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  T mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/key_diffuser.sv
// XOR diffusion of an 8-bit pixel stream with key bytes taken from buffered
// chaotic key triples. Define DIFFUSION_CHAIN_EN to enable ciphertext chaining.
module key_diffuser
  import chaos_pkg::*;
#(
  parameter int               KEY_FIFO_DEPTH = 4,
  parameter logic [PIX_W-1:0] IV             = 8'hA5,
  localparam int              CW             = $clog2(KEY_FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] key_val [0:2],
  input  logic             decrypt,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_last,
  output logic [CW-1:0]    key_count
);
  key_triple_t      key_in;
  key_triple_t      key_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             key_push;
  logic             key_pop;
  logic             accept;
  logic [1:0]       sel;
  logic [PIX_W-1:0] k;
  logic [PIX_W-1:0] res;

  always_comb begin
    key_in = '0;
    for (int i = 0; i < 3; i++) key_in[i] = key_val[i];
  end

  assign key_ready = !fifo_full;
  assign key_push  = key_valid && key_ready;
  assign pix_ready = !fifo_empty && (!out_valid || out_ready);
  assign accept    = pix_valid && pix_ready;
  // A frame end discards whatever is left of the current triple.
  assign key_pop   = accept && (sel == SEL_LAST || pix_last);

  key_fifo #(
    .DEPTH (KEY_FIFO_DEPTH),
    .T     (key_triple_t)
  ) u_key_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (key_push),
    .pop   (key_pop),
    .din   (key_in),
    .head  (key_head),
    .count (key_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    case (sel)
      2'd1:    k = key_head[1][PIX_W-1:0];
      2'd2:    k = key_head[2][PIX_W-1:0];
      default: k = key_head[0][PIX_W-1:0];
    endcase
  end

  logic unused_key_hi;
  assign unused_key_hi = ^{key_head[0][KEY_W-1:PIX_W], key_head[1][KEY_W-1:PIX_W],
                           key_head[2][KEY_W-1:PIX_W]};

`ifdef DIFFUSION_CHAIN_EN
  logic [PIX_W-1:0] prev;

  assign res = pix_data ^ k ^ prev;

  // Encrypt chains on the produced ciphertext, decrypt on the received one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         prev <= IV;
    else if (accept) prev <= pix_last ? IV : (decrypt ? pix_data : res);
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{decrypt, IV};
  assign res = pix_data ^ k;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         sel <= 2'd0;
    else if (accept) sel <= (pix_last || sel == SEL_LAST) ? 2'd0 : sel + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= res;
      out_last  <= pix_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/key_diffuser.md
# key_diffuser

Downstream of the fractional-digit extractor: buffers triples of 23-bit chaotic key values, reduces each value to a key byte, and applies XOR diffusion to an 8-bit pixel stream. One key triple covers three consecutive pixels, taken in channel order 0, 1, 2. The same block runs encryption and decryption, selected per frame, and sits between the extractor and the image-memory writer.

## Interface
- KEY_FIFO_DEPTH, 4, number of key triples buffered (power of two, ≥2)
- IV, 8'hA5, chaining seed loaded at reset and at every frame boundary
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- key_valid  in  1  key triple present on key_val
- key_ready  out  1  FIFO can accept a triple
- key_val  in  3×23  key values [0:2], unpacked array
- decrypt  in  1  0 = encrypt, 1 = decrypt; held stable for a whole frame
- pix_valid  in  1  pixel present
- pix_ready  out  1  pixel accepted this cycle when high with pix_valid
- pix_data  in  8  plaintext (encrypt) or ciphertext (decrypt)
- pix_last  in  1  marks last pixel of frame
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_data  out  8  processed pixel
- out_last  out  1  copy of pix_last for this result
- key_count  out  $clog2(KEY_FIFO_DEPTH+1)  FIFO occupancy in triples

## Operation
- Key push: when key_valid && key_ready, write the triple to the FIFO. key_ready = (key_count != KEY_FIFO_DEPTH). There is no pass-through; when full, key_ready is 0 even if a pop occurs in the same cycle.
- Key byte: k = key_val_head[sel][7:0], i.e. value mod 256. sel is a 2-bit counter that steps 0→1→2→0.
- Pixel accept: pix_ready = (key_count != 0) && (!out_valid || out_ready).
- Accept action:
  - register out_data, out_last = pix_last, out_valid = 1;
  - advance sel;
  - when sel was 2, pop the FIFO head.
- Result, with chaining: encrypt: out = p ^ k ^ prev, then prev ← out. Decrypt: out = c ^ k ^ prev, then prev ← c (the input byte).
- Frame end: when an accepted pixel has pix_last = 1:
  - prev ← IV and sel ← 0;
  - the head triple is popped even when sel ≠ 2, so partial triples are discarded and every frame starts on a fresh triple.
- Output hold: out_valid is cleared when out_ready && no new accept. out_data and out_last stay stable while out_valid && !out_ready.
- Simultaneous key push and pop: key_count stays unchanged, with the FIFO write and read pointers each advancing.
- Pointer wrap: modulo KEY_FIFO_DEPTH.

## Timing
- Reset values: out_valid 0, out_data 0, out_last 0, key_count 0, key_ready 1, pix_ready 0, sel 0, prev IV, FIFO pointers 0.
- Reset mid-frame: all in-flight state is dropped immediately, including buffered triples and the pending output.
- Latency: 1 cycle from pixel accept to out_valid.
- Throughput: 1 pixel/cycle while keys are available and out_ready = 1.
- A triple pushed in cycle N is usable for a pixel accept in cycle N+1; key_count updates at N+1.
- Key rate needed for full throughput: 1 triple per 3 cycles.

## Configuration
- DIFFUSION_CHAIN_EN defined: chaining as above.
  - prev register present;
  - IV used at reset and at each frame boundary.
- Undefined: out = pix_data ^ k for both modes.
  - prev register is not synthesized;
  - decrypt has no effect;
  - IV is unused.

## Structure
- Shared package chaos_pkg holds:
  - KEY_W = 23 and PIX_W = 8;
  - typedef key_triple_t, 3×KEY_W.
- The extractor's output width uses the same constants.
- Sub-module key_fifo is parameterized by depth and key_triple_t. It provides push, pop, head, count, and the full/empty flags.
- The top level contains sel, prev, the XOR datapath and the output register.

## Test plan
- Reset: hold rst high, then release → out_valid 0, key_ready 1, pix_ready 0, key_count 0.
- Chained encrypt (DIFFUSION_CHAIN_EN, IV 0xA5): push {10, 300, 999}, then send pixels 0x00, 0x00, 0x00 → out 0xAF, 0x83, 0x64; key_count returns to 0.
  - Macro undefined, same stimulus → out 0x0A, 0x2C, 0xE7.
- Decrypt round trip: feed 0xAF, 0x83, 0x64 with decrypt = 1 and the same triple → out 0x00, 0x00, 0x00.
- FIFO full: push 5 triples with no pixels → key_ready drops after the 4th, key_count = 4, 5th held until a triple is consumed.
- Backpressure: out_ready = 0 for 5 cycles with a result pending → out_data stable, pix_ready 0, no key consumed.
  - Release out_ready → stream resumes at 1 pixel/cycle.
- Frame boundary:
  - pix_last on the 2nd pixel of a triple → that triple is discarded (key_count −1);
  - the next pixel uses the channel-0 byte of the next triple, with prev = IV.
- Async reset mid-frame: FIFO empty and out_valid 0 in the same cycle.
